alu_stateful: RTL and testbench
===============================

ALU_STATEFUL -- requirements
Module: alu_stateful

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, ALU operand/container width; ADDR_WIDTH, 5, state RAM address width, depth 2^ADDR_WIDTH; PAGE_IDX_WIDTH, 4, page-table index width, 2^PAGE_IDX_WIDTH tenants; ACTION_LEN, 25, action word width, opcode in action_in[ACTION_LEN-1 -: 4].
REQ-002 SHALL have ports:
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous active-high reset.
- action_in, in, ACTION_LEN, action word.
- action_valid, in, 1, action offered.
- action_ready, out, 1, block can accept.
- operand_1_in, operand_2_in, operand_3_in, in, DATA_WIDTH each, operands.
- tenant_id, in, PAGE_IDX_WIDTH, page-table index.
- container_out, out, DATA_WIDTH, result.
- container_out_valid, out, 1, result strobe.
- bound_err, out, 1, bounds-violation strobe.
- cfg_wr_en, in, 1, page-table write.
- cfg_wr_idx, in, PAGE_IDX_WIDTH, page-table entry.
- cfg_wr_data, in, 2*ADDR_WIDTH, {len, base}.
REQ-003 One clock; reset asynchronous, active-high.

Function
REQ-004 Handshake SHALL accept on action_valid && action_ready; action_ready = 1 only in IDLE; operands, opcode, tenant_id captured at acceptance; later input changes ignored.
REQ-005 FSM SHALL be IDLE -> LOOKUP -> CHECK -> EXEC -> OUTPUT -> IDLE, one cycle per state; accept at cycle T gives container_out_valid high for exactly one cycle at T+4; next acceptance no earlier than T+5.
REQ-006 LOOKUP SHALL read page table[tenant_id] into base, len (ADDR_WIDTH each); CHECK SHALL compute offset = op2[ADDR_WIDTH-1:0], phys = (base + offset) mod 2^ADDR_WIDTH, and issue the synchronous RAM read at phys.
REQ-007 Opcodes, all others passing operand_3 through, no RAM access:
- 0001 add / 1001 addi: op1+op2.
- 0010 sub / 1010 subi: op1-op2.
- 1000 store: RAM[phys]=op1, output op3.
- 1011 load: output RAM[phys].
- 0111 loadd: output and write RAM[phys]+1.
- 0011 fetch-add: output old RAM[phys], write old+op1.
- 1100 CAS: output old, write op3 only if old==op1.
REQ-008 Bounds: for RAM opcodes, offset > len SHALL suppress the RAM write, output op3, pulse bound_err with container_out_valid; offset == len is legal.
REQ-009 RAM writes SHALL occur in EXEC; next action's read therefore sees the written value (no hazard).
REQ-010 Arithmetic and RAM increments SHALL wrap modulo 2^DATA_WIDTH unless REQ-015 applies; loadd at all-ones writes 0.
REQ-011 Page-table write SHALL take effect the next cycle; cfg write to the index read in the same LOOKUP cycle SHALL return the old entry; cfg writes are allowed in any state.
REQ-012 container_out SHALL hold its last value outside OUTPUT; bound_err is 0 outside OUTPUT.

Reset
REQ-013 rst SHALL immediately force state IDLE, container_out=0, container_out_valid=0, bound_err=0, all page-table entries {len=0, base=0}; action in flight is dropped, no RAM write.
REQ-014 RAM contents SHALL NOT be reset; action_ready=1 after reset release.

Configuration
REQ-015 With ALU_STATEFUL_SAT_EN defined, add/addi/fetch-add/loadd SHALL saturate unsigned at all-ones and sub/subi SHALL clamp at 0; without it, all wrap per REQ-010.

Verification
REQ-016 Page[2]={len=4, base=8}; store op1=0xAB, op2=3, tenant 2; then load op2=3 -> RAM[11]=0xAB, load output 0xAB at T+4.
REQ-017 Same page, store op2=5, op3=0x77 -> no write, output 0x77, bound_err=1; load op2=4 -> no bound_err.
REQ-018 RAM[phys]=0xFFFFFFFF, loadd -> output 0 and RAM 0 without ALU_STATEFUL_SAT_EN; 0xFFFFFFFF with it.
REQ-019 CAS with RAM=5: op1=5, op3=9 -> output 5, RAM 9; repeat -> output 9, RAM stays 9.
REQ-020 rst asserted at T+2 of a store -> outputs 0 immediately, RAM unchanged, action_ready=1 after release.
REQ-021 Back-to-back fetch-add op1=1 ×3 on RAM=0 with action_valid held -> outputs 0,1,2 at 5-cycle spacing.

Source files
------------

// File: rtl/alu_stateful.sv
// Stateful ALU with a tenant page table over a small state RAM.
// Latency: accept in cycle T, result strobe in cycle T+4, next accept no earlier than T+5.
// Backpressure: action_ready is high only in IDLE; one action is in flight at a time.
// Optional build macro ALU_STATEFUL_SAT_EN: unsigned saturation instead of wrap.
module alu_stateful #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int PAGE_IDX_WIDTH = 4,
  parameter int ACTION_LEN     = 25
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ACTION_LEN-1:0]       action_in,
  input  logic                        action_valid,
  output logic                        action_ready,
  input  logic [DATA_WIDTH-1:0]       operand_1_in,
  input  logic [DATA_WIDTH-1:0]       operand_2_in,
  input  logic [DATA_WIDTH-1:0]       operand_3_in,
  input  logic [PAGE_IDX_WIDTH-1:0]   tenant_id,
  output logic [DATA_WIDTH-1:0]       container_out,
  output logic                        container_out_valid,
  output logic                        bound_err,
  input  logic                        cfg_wr_en,
  input  logic [PAGE_IDX_WIDTH-1:0]   cfg_wr_idx,
  input  logic [2*ADDR_WIDTH-1:0]     cfg_wr_data
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int PAGES     = 1 << PAGE_IDX_WIDTH;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_LOADD = 4'b0111;
  localparam logic [3:0] OP_FADD  = 4'b0011;
  localparam logic [3:0] OP_CAS   = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_EXEC,
    S_OUTPUT
  } state_t;

  state_t state, state_nxt;

  logic                      accept;
  logic [3:0]                opc_q;
  logic [DATA_WIDTH-1:0]     op1_q, op2_q, op3_q;
  logic [PAGE_IDX_WIDTH-1:0] tid_q;
  logic [ADDR_WIDTH-1:0]     base_q, len_q, phys_q;
  logic [ADDR_WIDTH-1:0]     offset;
  logic                      viol_q;
  logic                      is_ram_op;
  logic [DATA_WIDTH-1:0]     rd_q;
  logic [2*ADDR_WIDTH-1:0]   page_tbl [PAGES];
  logic [DATA_WIDTH-1:0]     ram [RAM_DEPTH];

  logic [DATA_WIDTH-1:0]     res;
  logic                      ram_we;
  logic [DATA_WIDTH-1:0]     ram_wdat;

  // Only the opcode field of the action word carries meaning here.
  logic unused_action_bits;
  assign unused_action_bits = ^action_in[ACTION_LEN-5:0];

  assign accept    = action_valid && action_ready;
  assign offset    = op2_q[ADDR_WIDTH-1:0];
  assign is_ram_op = (opc_q == OP_STORE) || (opc_q == OP_LOAD) || (opc_q == OP_LOADD) ||
                     (opc_q == OP_FADD)  || (opc_q == OP_CAS);

  // Unsigned add: saturates at all-ones in the saturating build, wraps otherwise.
  function automatic logic [DATA_WIDTH-1:0] alu_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
`ifdef ALU_STATEFUL_SAT_EN
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  // Unsigned subtract: clamps at zero in the saturating build, wraps otherwise.
  function automatic logic [DATA_WIDTH-1:0] alu_sub(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
`ifdef ALU_STATEFUL_SAT_EN
    return (a < b) ? '0 : a - b;
`else
    return a - b;
`endif
  endfunction

  // State register; reset drops any action in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake: fixed one cycle per stage.
  always_comb begin
    state_nxt    = state;
    action_ready = 1'b0;
    case (state)
      S_IDLE: begin
        action_ready = 1'b1;
        if (action_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: state_nxt = S_CHECK;
      S_CHECK:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_OUTPUT;
      S_OUTPUT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Capture the action at acceptance, then page lookup and bounds/address stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q  <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      op3_q  <= '0;
      tid_q  <= '0;
      base_q <= '0;
      len_q  <= '0;
      phys_q <= '0;
      viol_q <= 1'b0;
    end else begin
      if (accept) begin
        opc_q <= action_in[ACTION_LEN-1 -: 4];
        op1_q <= operand_1_in;
        op2_q <= operand_2_in;
        op3_q <= operand_3_in;
        tid_q <= tenant_id;
      end
      // A cfg write landing on this same edge is not seen: old entry is used.
      if (state == S_LOOKUP) {len_q, base_q} <= page_tbl[tid_q];
      if (state == S_CHECK) begin
        phys_q <= base_q + offset;
        viol_q <= offset > len_q;
      end
    end
  end

  // Page table: writable in any state, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAGES; i++) page_tbl[i] <= '0;
    end else if (cfg_wr_en) begin
      page_tbl[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // State RAM: synchronous read in CHECK, write in EXEC; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == S_CHECK) rd_q <= ram[base_q + offset];
    if (ram_we && (state == S_EXEC)) ram[phys_q] <= ram_wdat;
  end

  // Execute: result and RAM update; out-of-bounds RAM ops pass operand 3 through.
  always_comb begin
    res      = op3_q;
    ram_we   = 1'b0;
    ram_wdat = rd_q;
    case (opc_q)
      OP_ADD, OP_ADDI: res = alu_add(op1_q, op2_q);
      OP_SUB, OP_SUBI: res = alu_sub(op1_q, op2_q);
      OP_STORE: begin
        ram_we   = !viol_q;
        ram_wdat = op1_q;
      end
      OP_LOAD: begin
        if (!viol_q) res = rd_q;
      end
      OP_LOADD: begin
        if (!viol_q) begin
          res      = alu_add(rd_q, {{(DATA_WIDTH-1){1'b0}}, 1'b1});
          ram_we   = 1'b1;
          ram_wdat = res;
        end
      end
      OP_FADD: begin
        if (!viol_q) begin
          res      = rd_q;
          ram_we   = 1'b1;
          ram_wdat = alu_add(rd_q, op1_q);
        end
      end
      OP_CAS: begin
        if (!viol_q) begin
          res      = rd_q;
          ram_we   = (rd_q == op1_q);
          ram_wdat = op3_q;
        end
      end
      default: res = op3_q;
    endcase
  end

  // Result registers: strobes live for the single OUTPUT cycle, data holds afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      container_out       <= '0;
      container_out_valid <= 1'b0;
      bound_err           <= 1'b0;
    end else begin
      container_out_valid <= 1'b0;
      bound_err           <= 1'b0;
      if (state == S_EXEC) begin
        container_out       <= res;
        container_out_valid <= 1'b1;
        bound_err           <= viol_q && is_ram_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_stateful.sv
// Bench for alu_stateful: table of actions plus hand sequences for
// lookup/cfg race, reset in flight and back-to-back fetch-add.
// Results are checked by a scoreboard queue popped on each output strobe.
module tb_alu_stateful;

`ifdef ALU_STATEFUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'b0001, ADDI = 4'b1001, SUB = 4'b0010, SUBI = 4'b1010;
  localparam logic [3:0] STO = 4'b1000, LD = 4'b1011, LDD = 4'b0111, FAD = 4'b0011;
  localparam logic [3:0] CAS = 4'b1100, NOP = 4'b0000, OTH = 4'b0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] action_in = '0;
  logic        action_valid = 1'b0;
  logic        action_ready;
  logic [31:0] operand_1_in = '0, operand_2_in = '0, operand_3_in = '0;
  logic [3:0]  tenant_id = '0;
  logic [31:0] container_out;
  logic        container_out_valid;
  logic        bound_err;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_wr_idx = '0;
  logic [9:0]  cfg_wr_data = '0;

  alu_stateful dut (
    .clk(clk), .rst(rst),
    .action_in(action_in), .action_valid(action_valid), .action_ready(action_ready),
    .operand_1_in(operand_1_in), .operand_2_in(operand_2_in), .operand_3_in(operand_3_in),
    .tenant_id(tenant_id),
    .container_out(container_out), .container_out_valid(container_out_valid),
    .bound_err(bound_err),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] eo;
    logic        ee;
    int          acc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] o1, o2, o3;
    logic [3:0]  tid;
    logic [31:0] eo;
    logic        ee;
  } vec_t;
  vec_t vt[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic v(input logic [3:0] op, input logic [31:0] o1, input logic [31:0] o2,
                   input logic [31:0] o3, input logic [3:0] tid, input logic [31:0] eo,
                   input logic ee);
    vec_t r;
    r.op = op; r.o1 = o1; r.o2 = o2; r.o3 = o3; r.tid = tid; r.eo = eo; r.ee = ee;
    vt.push_back(r);
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [4:0] len, input logic [4:0] base);
    cfg_wr_en   = 1'b1;
    cfg_wr_idx  = idx;
    cfg_wr_data = {len, base};
    @(posedge clk); #1;
    cfg_wr_en   = 1'b0;
  endtask

  // Offer one action; returns one step after the accepting edge (in LOOKUP).
  task automatic do_action(input logic [3:0] op, input logic [31:0] o1, input logic [31:0] o2,
                           input logic [31:0] o3, input logic [3:0] tid, input logic [31:0] eo,
                           input logic ee, input bit push, input bit hold, output int acc);
    int   n;
    exp_t e;
    action_in    = {op, 21'($urandom)};
    operand_1_in = o1;
    operand_2_in = o2;
    operand_3_in = o3;
    tenant_id    = tid;
    action_valid = 1'b1;
    n = 0;
    while (!action_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    acc = cyc;
    if (!action_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: action_ready stayed %b, required 1", action_ready);
      action_valid = 1'b0;
    end else begin
      if (push) begin
        e.eo = eo; e.ee = ee; e.acc = acc;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      // Inputs after acceptance must be ignored by the DUT.
      action_in    = 25'($urandom);
      operand_1_in = $urandom;
      operand_2_in = $urandom;
      operand_3_in = $urandom;
      tenant_id    = 4'($urandom);
      if (!hold) action_valid = 1'b0;
    end
  endtask

  initial begin
    int a1, a2, a3, n;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (container_out_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got %h with no pending action", container_out);
          end else begin
            e = sb.pop_front();
            chk("container_out", container_out, e.eo);
            chk("bound_err", 32'(bound_err), 32'(e.ee));
            chk("latency_cycle", 32'(cyc), 32'(e.acc + 4));
          end
        end else if (bound_err) begin
          checks++; errors++;
          $display("FAIL bound_err_without_valid: got 1 required 0");
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_container_out", container_out, 32'h0);
    chk("rst_valid", 32'(container_out_valid), 32'h0);
    chk("rst_bound_err", 32'(bound_err), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(action_ready), 32'h1);

    cfg_write(4'd2, 5'd4, 5'd8);
    cfg_write(4'd3, 5'd31, 5'd0);
    cfg_write(4'd4, 5'd31, 5'd30);

    v(ADD,  32'd10,        32'd3,   32'h0,   4'd2, 32'd13, 1'b0);
    v(ADDI, 32'hFFFFFFFF,  32'd2,   32'h0,   4'd2, SAT ? 32'hFFFFFFFF : 32'd1, 1'b0);
    v(SUB,  32'd5,         32'd7,   32'h0,   4'd2, SAT ? 32'd0 : 32'hFFFFFFFE, 1'b0);
    v(SUBI, 32'd100,       32'd1,   32'h0,   4'd2, 32'd99, 1'b0);
    v(NOP,  32'd1,         32'd2,   32'h1234, 4'd2, 32'h1234, 1'b0);
    v(OTH,  32'd1,         32'd2,   32'hBEEF, 4'd2, 32'hBEEF, 1'b0);
    v(STO,  32'h13,        32'd13,  32'h1,   4'd3, 32'h1, 1'b0);
    v(STO,  32'hAB,        32'd3,   32'h55,  4'd2, 32'h55, 1'b0);
    v(LD,   32'h0,         32'd3,   32'h0,   4'd2, 32'hAB, 1'b0);
    v(STO,  32'hEE,        32'd5,   32'h77,  4'd2, 32'h77, 1'b1);
    v(LD,   32'h0,         32'd13,  32'h0,   4'd3, 32'h13, 1'b0);
    v(STO,  32'h44,        32'd4,   32'h0,   4'd2, 32'h0, 1'b0);
    v(LD,   32'h0,         32'd4,   32'h0,   4'd2, 32'h44, 1'b0);
    v(STO,  32'hFFFFFFFF,  32'd1,   32'h2,   4'd2, 32'h2, 1'b0);
    v(LDD,  32'h0,         32'd1,   32'h3,   4'd2, SAT ? 32'hFFFFFFFF : 32'h0, 1'b0);
    v(LD,   32'h0,         32'd1,   32'h0,   4'd2, SAT ? 32'hFFFFFFFF : 32'h0, 1'b0);
    v(STO,  32'd5,         32'd2,   32'h4,   4'd2, 32'h4, 1'b0);
    v(CAS,  32'd5,         32'd2,   32'd9,   4'd2, 32'd5, 1'b0);
    v(LD,   32'h0,         32'd2,   32'h0,   4'd2, 32'd9, 1'b0);
    v(CAS,  32'd5,         32'd2,   32'd9,   4'd2, 32'd9, 1'b0);
    v(LD,   32'h0,         32'd2,   32'h0,   4'd2, 32'd9, 1'b0);
    v(FAD,  32'd1,         32'd6,   32'h66,  4'd2, 32'h66, 1'b1);
    v(STO,  32'hC0DE,      32'd3,   32'h7,   4'd4, 32'h7, 1'b0);
    v(LD,   32'h0,         32'd1,   32'h0,   4'd3, 32'hC0DE, 1'b0);
    v(STO,  32'h31,        32'd0,   32'h8,   4'd0, 32'h8, 1'b0);
    v(LD,   32'h0,         32'd1,   32'h99,  4'd0, 32'h99, 1'b1);
    v(LD,   32'h0,         32'd0,   32'h0,   4'd0, 32'h31, 1'b0);
    v(STO,  32'h22,        32'd2,   32'h0,   4'd3, 32'h0, 1'b0);
    v(STO,  32'h2020,      32'd20,  32'h0,   4'd3, 32'h0, 1'b0);
    v(STO,  32'hFFFFFFF0,  32'd15,  32'h0,   4'd3, 32'h0, 1'b0);
    v(FAD,  32'h20,        32'd15,  32'h0,   4'd3, 32'hFFFFFFF0, 1'b0);
    v(LD,   32'h0,         32'd15,  32'h0,   4'd3, SAT ? 32'hFFFFFFFF : 32'h10, 1'b0);
    v(LD,   32'h0,         32'h103, 32'h0,   4'd2, 32'hAB, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      do_action(vt[i].op, vt[i].o1, vt[i].o2, vt[i].o3, vt[i].tid, vt[i].eo, vt[i].ee,
                1'b1, 1'b0, a1);
    end

    // cfg write during LOOKUP of the same tenant: old entry {0,0} is used.
    do_action(LD, 32'h0, 32'd2, 32'h5A, 4'd5, 32'h5A, 1'b1, 1'b1, 1'b0, a1);
    cfg_write(4'd5, 5'd31, 5'd0);
    do_action(LD, 32'h0, 32'd2, 32'h0, 4'd5, 32'h22, 1'b0, 1'b1, 1'b0, a1);

    // Reset asserted in CHECK of a store: no write, outputs cleared at once.
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1;
    do_action(STO, 32'hDEAD, 32'd20, 32'h0, 4'd3, 32'h0, 1'b0, 1'b0, 1'b0, a1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_container_out", container_out, 32'h0);
    chk("midrst_valid", 32'(container_out_valid), 32'h0);
    chk("midrst_bound_err", 32'(bound_err), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(action_ready), 32'h1);
    cfg_write(4'd3, 5'd31, 5'd0);
    do_action(LD, 32'h0, 32'd20, 32'h0, 4'd3, 32'h2020, 1'b0, 1'b1, 1'b0, a1);

    // Back-to-back fetch-add with action_valid held.
    do_action(STO, 32'h0, 32'd21, 32'h0, 4'd3, 32'h0, 1'b0, 1'b1, 1'b0, a1);
    do_action(FAD, 32'd1, 32'd21, 32'h0, 4'd3, 32'd0, 1'b0, 1'b1, 1'b1, a1);
    do_action(FAD, 32'd1, 32'd21, 32'h0, 4'd3, 32'd1, 1'b0, 1'b1, 1'b1, a2);
    do_action(FAD, 32'd1, 32'd21, 32'h0, 4'd3, 32'd2, 1'b0, 1'b1, 1'b1, a3);
    action_valid = 1'b0;
    chk("b2b_spacing_1", 32'(a2 - a1), 32'd5);
    chk("b2b_spacing_2", 32'(a3 - a2), 32'd5);
    do_action(LD, 32'h0, 32'd21, 32'h0, 4'd3, 32'd3, 1'b0, 1'b1, 1'b0, a1);

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
